branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Parametrised branch target buffer with per-entry 2-bit saturating direction counters, valid bits, automatic allocation and round-robin replacement. It sits beside the fetch-stage PC mux. Fetch presents the current PC for a same-cycle prediction plus a one-cycle-delayed copy of the prediction. The branch-resolution stage writes outcomes back through a single update port; the block itself decides hit/allocate/replace, so the controller no longer supplies slot addresses.

## Interface
- PC_W, 16, width of PC and target fields
- ENTRIES, 8, number of entries; power of two, ≥2; IDX_W = clog2(ENTRIES)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- lookup_pc  in  PC_W  fetch PC to predict
- pred_hit  out  1  combinational: lookup_pc matches a valid entry
- pred_taken  out  1  combinational: MSB of hit entry's counter; 0 on miss
- pred_target  out  PC_W  combinational: hit entry's target; 0 on miss
- pred_taken_q  out  1  pred_taken registered one cycle
- pred_target_q  out  PC_W  pred_target registered one cycle
- upd_valid  in  1  resolved-branch update strobe
- upd_pc  in  PC_W  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  PC_W  actual target (meaningful when upd_taken=1)
- flush  in  1  synchronous invalidate of all entries
- upd_hit  out  1  combinational: upd_pc matches a valid entry

## Operation
- Entry state: valid, tag[PC_W] (full PC), target[PC_W], ctr[2].
- Lookup: tag compare of lookup_pc against all valid entries; lowest-index match wins (duplicates cannot arise, see allocation).
- Update with upd_valid=1, upd_hit=1: ctr saturating +1 if taken, −1 if not taken (3→3, 0→0); target overwritten with upd_target only when taken.
- Update with upd_valid=1, miss, upd_taken=1: allocate. Victim = lowest-index invalid entry if any, else entry at rr_ptr; rr_ptr advances by one (mod ENTRIES) only when a valid entry is evicted. New entry: valid=1, tag=upd_pc, target=upd_target, ctr=WEAK_T (2).
- Update, miss, not taken: no state change.
- flush=1: all valid bits cleared, rr_ptr→0; flush overrides a same-cycle update (update dropped). Counters/targets/tags are not cleared.
- Reset (async): all valid=0, tags/targets=0, ctr=WEAK_NT (1), rr_ptr=0, pred_taken_q=0, pred_target_q=0.

## Timing
- pred_* are combinational from lookup_pc and current array state (zero latency).
- pred_*_q = value of pred_* sampled at the rising edge; one-cycle latency; during reset both 0.
- Update takes effect at the rising edge where upd_valid=1; visible to lookup from the next cycle.
- Same-cycle lookup and update of the same PC: lookup returns pre-update state (read-before-write), and pred_*_q captures that pre-update value.
- Reset deassertion mid-operation: first edge after deassertion behaves as a normal edge; no pending update survives reset.
- Back-to-back updates to the same PC on consecutive cycles each apply (second sees first's result); no stall or ready signal exists.

## Structure
- Shared package bp_pkg: counter encodings STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3, constants CTR_RESET=WEAK_NT, CTR_ALLOC=WEAK_T, and the saturating inc/dec function.
- One sub-module, bp_cam_match (parameters PC_W, ENTRIES): key + tag vector + valid vector → hit, one-hot match, encoded lowest index. Instantiated twice (lookup port, update port). Victim selection (first-invalid priority encoder + rr_ptr) lives in the top.

## Test plan
- Reset then lookup_pc=0x0000 → pred_hit=0, pred_taken=0, pred_target=0 (tag 0 with valid=0 must not hit).
- Update pc=0x0010 taken target=0x0040; next cycle lookup 0x0010 → hit, taken=1, target=0x0040; following cycle pred_target_q=0x0040.
- Counter saturation on 0x0010: three not-taken updates → taken=0 after the first (ctr 2→1→0→0); then one taken → ctr 1, still predicts not-taken; second taken → predicts taken.
- Fill ENTRIES=8 with pcs 0x0100..0x0107 taken; ninth taken pc 0x0200 evicts entry 0 (0x0100 misses, 0x0200 hits), tenth evicts entry 1; not-taken miss pc 0x0300 allocates nothing.
- Same cycle lookup and taken-update of new pc 0x0500 → pred_hit=0 that cycle, pred_hit=1 next cycle; flush asserted with a concurrent update → all lookups miss, update dropped.
- Assert reset asynchronously mid-cycle after populated entries → pred_*_q=0 immediately, all lookups miss after release.

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg : shared branch-predictor types, counter encodings and helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } ctr_e;

  localparam ctr_e CTR_RESET = WEAK_NT;
  localparam ctr_e CTR_ALLOC = WEAK_T;

  // Saturating step toward the observed outcome.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    case (c)
      STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  n = taken ? STRONG_T : WEAK_T;
      default:   n = c;
    endcase
    return n;
  endfunction

  function automatic logic ctr_taken(input ctr_e c);
    return (c == WEAK_T) || (c == STRONG_T);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_cam_match.sv
// ---------------------------------------------------------------------------
// bp_cam_match : full-tag compare against valid entries, lowest index wins
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_cam_match #(
  parameter  int PC_W    = 16,
  parameter  int ENTRIES = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [PC_W-1:0]               i_key,
  input  logic [ENTRIES-1:0][PC_W-1:0]  i_tags,
  input  logic [ENTRIES-1:0]            i_valid,
  output logic                          o_hit,
  output logic [ENTRIES-1:0]            o_match,
  output logic [IDX_W-1:0]              o_idx
);

  logic [ENTRIES-1:0] w_raw;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign w_raw[g] = i_valid[g] && (i_tags[g] == i_key);
  end

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    o_idx   = '0;
    o_match = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_raw[i]) begin
        o_idx      = IDX_W'(i);
        o_match    = '0;
        o_match[i] = 1'b1;
      end
    end
  end

  assign o_hit = |w_raw;

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer : fully-associative BTB with 2-bit counters and RR victim
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_target_buffer
  import bp_pkg::*;
#(
  parameter  int PC_W    = 16,
  parameter  int ENTRIES = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] i_lookup_pc,
  output logic            o_pred_hit,
  output logic            o_pred_taken,
  output logic [PC_W-1:0] o_pred_target,
  output logic            o_pred_taken_q,
  output logic [PC_W-1:0] o_pred_target_q,
  input  logic            i_upd_valid,
  input  logic [PC_W-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [PC_W-1:0] i_upd_target,
  input  logic            i_flush,
  output logic            o_upd_hit
);

  logic [ENTRIES-1:0]           r_valid;
  logic [ENTRIES-1:0][PC_W-1:0] r_tag;
  logic [ENTRIES-1:0][PC_W-1:0] r_target;
  ctr_e                         r_ctr [ENTRIES];
  logic [IDX_W-1:0]             r_rr_ptr;

  logic                         w_lk_hit;
  logic [ENTRIES-1:0]           w_lk_match;
  logic [IDX_W-1:0]             w_lk_idx;
  logic                         w_up_hit;
  logic [ENTRIES-1:0]           w_up_match;
  logic [IDX_W-1:0]             w_up_idx;
  ctr_e                         w_up_ctr_nxt;
  logic [PC_W-1:0]              w_lk_target;
  logic [IDX_W-1:0]             w_free_idx;
  logic                         w_any_free;
  logic [IDX_W-1:0]             w_victim;

  bp_cam_match #(.PC_W(PC_W), .ENTRIES(ENTRIES)) u_cam_lookup (
    .i_key   (i_lookup_pc),
    .i_tags  (r_tag),
    .i_valid (r_valid),
    .o_hit   (w_lk_hit),
    .o_match (w_lk_match),
    .o_idx   (w_lk_idx)
  );

  bp_cam_match #(.PC_W(PC_W), .ENTRIES(ENTRIES)) u_cam_update (
    .i_key   (i_upd_pc),
    .i_tags  (r_tag),
    .i_valid (r_valid),
    .o_hit   (w_up_hit),
    .o_match (w_up_match),
    .o_idx   (w_up_idx)
  );

  // Match is one-hot, so an AND-OR mux selects the target without a decoder.
  always_comb begin
    w_lk_target = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_lk_target = w_lk_target | (r_target[i] & {PC_W{w_lk_match[i]}});
    end
  end

  assign o_pred_hit    = w_lk_hit;
  assign o_pred_taken  = w_lk_hit & ctr_taken(r_ctr[w_lk_idx]);
  assign o_pred_target = w_lk_target;
  assign o_upd_hit     = w_up_hit;
  assign w_up_ctr_nxt  = ctr_next(r_ctr[w_up_idx], i_upd_taken);

  always_comb begin
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  assign w_any_free = ~&r_valid;
  assign w_victim   = w_any_free ? w_free_idx : r_rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_tag    <= '0;
      r_target <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_RESET;
    end else if (i_flush) begin
      r_valid  <= '0;
      r_rr_ptr <= '0;
    end else if (i_upd_valid) begin
      if (w_up_hit) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (w_up_match[i]) begin
            r_ctr[i] <= w_up_ctr_nxt;
            if (i_upd_taken) r_target[i] <= i_upd_target;
          end
        end
      end else if (i_upd_taken) begin
        r_valid[w_victim]  <= 1'b1;
        r_tag[w_victim]    <= i_upd_pc;
        r_target[w_victim] <= i_upd_target;
        r_ctr[w_victim]    <= CTR_ALLOC;
        // Pointer only moves when a live entry is displaced.
        if (!w_any_free) r_rr_ptr <= r_rr_ptr + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pred_taken_q  <= 1'b0;
      o_pred_target_q <= '0;
    end else begin
      o_pred_taken_q  <= o_pred_taken;
      o_pred_target_q <= o_pred_target;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer : directed self-checking bench for branch_target_buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [15:0] i_lookup_pc;
  logic        o_pred_hit;
  logic        o_pred_taken;
  logic [15:0] o_pred_target;
  logic        o_pred_taken_q;
  logic [15:0] o_pred_target_q;
  logic        i_upd_valid;
  logic [15:0] i_upd_pc;
  logic        i_upd_taken;
  logic [15:0] i_upd_target;
  logic        i_flush;
  logic        o_upd_hit;

  int n_pass;
  int n_total;

  branch_target_buffer #(.PC_W(16), .ENTRIES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_lookup_pc     (i_lookup_pc),
    .o_pred_hit      (o_pred_hit),
    .o_pred_taken    (o_pred_taken),
    .o_pred_target   (o_pred_target),
    .o_pred_taken_q  (o_pred_taken_q),
    .o_pred_target_q (o_pred_target_q),
    .i_upd_valid     (i_upd_valid),
    .i_upd_pc        (i_upd_pc),
    .i_upd_taken     (i_upd_taken),
    .i_upd_target    (i_upd_target),
    .i_flush         (i_flush),
    .o_upd_hit       (o_upd_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [15:0] pc, input logic hit,
                      input logic taken, input logic [15:0] tgt);
    i_lookup_pc = pc;
    #1;
    chk({tag, ".hit"},    {15'd0, o_pred_hit},   {15'd0, hit});
    chk({tag, ".taken"},  {15'd0, o_pred_taken}, {15'd0, taken});
    chk({tag, ".target"}, o_pred_target,         tgt);
  endtask

  task automatic upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
    i_upd_valid  = 1'b1;
    i_upd_pc     = pc;
    i_upd_taken  = taken;
    i_upd_target = tgt;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst          = 1'b1;
    i_lookup_pc  = '0;
    i_upd_valid  = 1'b0;
    i_upd_pc     = '0;
    i_upd_taken  = 1'b0;
    i_upd_target = '0;
    i_flush      = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.taken_q",  {15'd0, o_pred_taken_q}, 16'd0);
    chk("rst.target_q", o_pred_target_q,          16'd0);
    rst = 1'b0;
    look("rst.pc0", 16'h0000, 1'b0, 1'b0, 16'h0000);

    // First allocation; lookup in the same cycle sees the empty table.
    upd(16'h0010, 1'b1, 16'h0040);
    look("alloc.same", 16'h0010, 1'b0, 1'b0, 16'h0000);
    chk("alloc.upd_hit", {15'd0, o_upd_hit}, 16'd0);
    tick();
    i_upd_valid = 1'b0;
    chk("alloc.taken_q_pre", {15'd0, o_pred_taken_q}, 16'd0);
    look("alloc.next", 16'h0010, 1'b1, 1'b1, 16'h0040);
    tick();
    chk("alloc.taken_q",  {15'd0, o_pred_taken_q}, 16'd1);
    chk("alloc.target_q", o_pred_target_q,          16'h0040);

    // Counter walk 2 -> 1 -> 0 -> 0 -> 1 -> 2 with back-to-back updates.
    upd(16'h0010, 1'b0, 16'h0099);
    #1;
    chk("ctr.upd_hit", {15'd0, o_upd_hit}, 16'd1);
    tick();
    look("ctr.nt1", 16'h0010, 1'b1, 1'b0, 16'h0040);
    tick();
    look("ctr.nt2", 16'h0010, 1'b1, 1'b0, 16'h0040);
    tick();
    look("ctr.nt3", 16'h0010, 1'b1, 1'b0, 16'h0040);
    upd(16'h0010, 1'b1, 16'h0044);
    tick();
    look("ctr.t1", 16'h0010, 1'b1, 1'b0, 16'h0044);
    tick();
    i_upd_valid = 1'b0;
    look("ctr.t2", 16'h0010, 1'b1, 1'b1, 16'h0044);

    // Flush wins over a concurrent allocation.
    i_flush = 1'b1;
    upd(16'h0600, 1'b1, 16'h6000);
    tick();
    i_flush     = 1'b0;
    i_upd_valid = 1'b0;
    look("flush.old", 16'h0010, 1'b0, 1'b0, 16'h0000);
    look("flush.drop", 16'h0600, 1'b0, 1'b0, 16'h0000);

    // Fill all eight entries, then replacement walks the round-robin pointer.
    for (int i = 0; i < 8; i++) begin
      upd(16'h0100 + 16'(i), 1'b1, 16'h1000 + 16'(i));
      tick();
    end
    i_upd_valid = 1'b0;
    look("fill.e0", 16'h0100, 1'b1, 1'b1, 16'h1000);
    look("fill.e7", 16'h0107, 1'b1, 1'b1, 16'h1007);
    upd(16'h0200, 1'b1, 16'h2000);
    tick();
    upd(16'h0201, 1'b1, 16'h2001);
    look("evict0.old", 16'h0100, 1'b0, 1'b0, 16'h0000);
    look("evict0.new", 16'h0200, 1'b1, 1'b1, 16'h2000);
    tick();
    upd(16'h0300, 1'b0, 16'h3000);
    #1;
    chk("nt_miss.upd_hit", {15'd0, o_upd_hit}, 16'd0);
    look("evict1.old", 16'h0101, 1'b0, 1'b0, 16'h0000);
    look("evict1.new", 16'h0201, 1'b1, 1'b1, 16'h2001);
    tick();
    upd(16'h0202, 1'b1, 16'h2002);
    look("nt_miss.none", 16'h0300, 1'b0, 1'b0, 16'h0000);
    look("nt_miss.keep", 16'h0102, 1'b1, 1'b1, 16'h1002);
    tick();
    i_upd_valid = 1'b0;
    look("evict2.old", 16'h0102, 1'b0, 1'b0, 16'h0000);
    look("evict2.new", 16'h0202, 1'b1, 1'b1, 16'h2002);
    look("evict2.keep", 16'h0103, 1'b1, 1'b1, 16'h1003);

    // Same-cycle lookup and allocate of one PC: read-before-write.
    upd(16'h0500, 1'b1, 16'h5000);
    look("rbw.same", 16'h0500, 1'b0, 1'b0, 16'h0000);
    tick();
    i_upd_valid = 1'b0;
    chk("rbw.taken_q",  {15'd0, o_pred_taken_q}, 16'd0);
    chk("rbw.target_q", o_pred_target_q,          16'h0000);
    look("rbw.next", 16'h0500, 1'b1, 1'b1, 16'h5000);
    tick();
    chk("rbw.taken_q2",  {15'd0, o_pred_taken_q}, 16'd1);
    chk("rbw.target_q2", o_pred_target_q,          16'h5000);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst.taken_q",  {15'd0, o_pred_taken_q}, 16'd0);
    chk("arst.target_q", o_pred_target_q,          16'h0000);
    chk("arst.hit",      {15'd0, o_pred_hit},     16'd0);
    @(negedge clk);
    rst = 1'b0;
    look("arst.e500", 16'h0500, 1'b0, 1'b0, 16'h0000);
    look("arst.e200", 16'h0200, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("arst.taken_q2", {15'd0, o_pred_taken_q}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
